// File: rtl/adc_axis_packer_pkg.sv
// Shared types for the hydrophone sample path (packer and max-finder).
package adc_stream_pkg;
  localparam int NUM_CH = 4;
  localparam int LANE_W = 16;

  typedef logic signed [NUM_CH-1:0][LANE_W-1:0] sample_set_t;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} pack_state_t;

  // Lane pair for one stream beat: hi=0 -> {ch1,ch0}, hi=1 -> {ch3,ch2}.
  function automatic logic [2*LANE_W-1:0] lane_pair(sample_set_t s, logic hi);
    return hi ? {s[3], s[2]} : {s[1], s[0]};
  endfunction
endpackage

// File: rtl/adc_axis_packer_if.sv
// AXI4-Stream master/slave bundle carrying packed ADC lane pairs.
interface adc_axis_if #(parameter int DW = 32);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/adc_axis_packer_fifo.sv
// Small register FIFO; a push into a full FIFO is taken when a pop happens
// in the same cycle. rd_next exposes the entry behind the head so the
// consumer can start the following frame without a bubble.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_next,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]               level_q;
  logic                        do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_next = mem_q[AW'(rd_ptr_q + AW'(1))];

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= AW'(wr_ptr_q + AW'(1));
      if (do_pop)  rd_ptr_q <= AW'(rd_ptr_q + AW'(1));
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

// File: rtl/adc_axis_packer.sv
// ADC 4-channel sample-set packer: captures sets into a FIFO and emits each
// as a 2-beat AXI4-Stream frame ({ch1,ch0} then {ch3,ch2} with tlast).
// Optional macro ADC_TEST_PATTERN_EN adds a test_mode input that replaces
// accepted sets with a ramp {base+3,base+2,base+1,base}.
module adc_axis_packer
  import adc_stream_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLE_WIDTH         = 16,
  parameter int FIFO_DEPTH           = 8,
  parameter int DROP_CNT_WIDTH       = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      m_axis_aclk,
  input  logic                      m_axis_aresetn,
  input  logic                      sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]   sample_ch0,
  input  logic [SAMPLE_WIDTH-1:0]   sample_ch1,
  input  logic [SAMPLE_WIDTH-1:0]   sample_ch2,
  input  logic [SAMPLE_WIDTH-1:0]   sample_ch3,
  input  logic                      overflow_clr,
`ifdef ADC_TEST_PATTERN_EN
  input  logic                      test_mode,
`endif
  adc_axis_if.master                m_axis,
  output logic [LW-1:0]             fifo_level,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  if (C_M_AXIS_TDATA_WIDTH != 32) begin : g_bad_tdata_w
    $error("adc_axis_packer: C_M_AXIS_TDATA_WIDTH must be 32");
  end
  if (SAMPLE_WIDTH < 1 || SAMPLE_WIDTH > LANE_W) begin : g_bad_sample_w
    $error("adc_axis_packer: SAMPLE_WIDTH must be 1..16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("adc_axis_packer: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic clk, rst_n;
  logic [1:0] rst_sync_q;

  assign clk   = m_axis_aclk;
  assign rst_n = rst_sync_q[1];

  // Reset asserts immediately, releases two clocks after aresetn rises.
  always_ff @(posedge clk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) rst_sync_q <= 2'b00;
    else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  // Lane widening: each raw sample is sign-extended to a full lane.
  logic [NUM_CH-1:0][SAMPLE_WIDTH-1:0] raw;
  sample_set_t adc_set, wr_set, head_set, next_set, fifo_next;

  assign raw = {sample_ch3, sample_ch2, sample_ch1, sample_ch0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign adc_set[g] = LANE_W'($signed(raw[g]));
  end

  logic push, pop, drop, full, empty, more;
  pack_state_t state_q, state_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0] tdata_q, tdata_d;

  assign pop  = (state_q == BEAT1) && tvalid_q && m_axis.tready;
  assign push = sample_valid && (!full || pop);
  assign drop = sample_valid && full && !pop;

`ifdef ADC_TEST_PATTERN_EN
  logic [LANE_W-1:0] base_q;
  sample_set_t       ramp_set;

  // Ramp base advances once per accepted set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    base_q <= '0;
    else if (push) base_q <= base_q + LANE_W'(4);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ramp
    assign ramp_set[g] = base_q + LANE_W'(g);
  end

  assign wr_set = test_mode ? ramp_set : adc_set;
`else
  assign wr_set = adc_set;
`endif

  sync_fifo #(.WIDTH(NUM_CH * LANE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_set),
    .rd_data (head_set),
    .rd_next (fifo_next),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  // Set that follows the one being popped: the next stored entry, or the
  // set being written this cycle when the head is the only one stored.
  assign more     = (fifo_level > LW'(1)) || push;
  assign next_set = (fifo_level > LW'(1)) ? fifo_next : wr_set;

  // Frame sequencer: next state and next registered stream outputs.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    case (state_q)
      IDLE: if (!empty) begin
        state_d  = BEAT0;
        tvalid_d = 1'b1;
        tlast_d  = 1'b0;
        tdata_d  = lane_pair(head_set, 1'b0);
      end
      BEAT0: if (tvalid_q && m_axis.tready) begin
        state_d = BEAT1;
        tlast_d = 1'b1;
        tdata_d = lane_pair(head_set, 1'b1);
      end
      BEAT1: if (tvalid_q && m_axis.tready) begin
        tlast_d = 1'b0;
        if (more) begin
          state_d = BEAT0;
          tdata_d = lane_pair(next_set, 1'b0);
        end else begin
          state_d  = IDLE;
          tvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and stream output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;

  logic                      ovf_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  // Drop tracking; a clear in the same cycle as a drop still counts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (overflow_clr) begin
      ovf_q  <= drop;
      drop_q <= DROP_CNT_WIDTH'(drop);
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != {DROP_CNT_WIDTH{1'b1}}) drop_q <= drop_q + DROP_CNT_WIDTH'(1);
    end
  end

  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_adc_axis_packer.sv
// Bench for adc_axis_packer: scenario tasks against a queue-based frame model.
module tb_adc_axis_packer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b1, sv = 1'b0, clr = 1'b0;
  logic [15:0] ch [4];
  logic [3:0]  lvl;
  logic        ovf;
  logic [15:0] dcnt;
  logic        sv12 = 1'b0;
  logic [11:0] ch12 [4];
  logic [3:0]  lvl12;
  logic        ovf12;
  logic [15:0] dcnt12;

  adc_axis_if axis();
  adc_axis_if axis12();

  int          n_chk = 0, n_err = 0;
  logic [63:0] exp_q[$];
  int          beat = 0, m_drop = 0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  adc_axis_packer #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .sample_valid(sv),
    .sample_ch0(ch[0]), .sample_ch1(ch[1]), .sample_ch2(ch[2]), .sample_ch3(ch[3]),
    .overflow_clr(clr),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .m_axis(axis), .fifo_level(lvl), .overflow(ovf), .drop_count(dcnt));

  adc_axis_packer #(.SAMPLE_WIDTH(12), .FIFO_DEPTH(DEPTH)) dut12 (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .sample_valid(sv12),
    .sample_ch0(ch12[0]), .sample_ch1(ch12[1]), .sample_ch2(ch12[2]), .sample_ch3(ch12[3]),
    .overflow_clr(1'b0),
`ifdef ADC_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .m_axis(axis12), .fifo_level(lvl12), .overflow(ovf12), .drop_count(dcnt12));

  task automatic model_reset();
    exp_q.delete();
    beat = 0; m_drop = 0; m_ovf = 1'b0;
  endtask

  task automatic rand_set();
    for (int k = 0; k < 4; k++) ch[k] = 16'($urandom);
  endtask

  // One clock: score the beat handshaken at this edge, update the model, and
  // confirm a stalled beat stays put. Called at posedge+1, returns at posedge+1.
  task automatic tick();
    logic hs, pop, drop, pv, pl;
    logic [31:0] pd, want;
    logic [63:0] head;
    hs = axis.tvalid && axis.tready;
    pv = axis.tvalid && !axis.tready;
    pd = axis.tdata; pl = axis.tlast;
    pop = 1'b0; drop = 1'b0;
    if (hs) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got tdata=%08h, want no beat", axis.tdata);
      end else begin
        head = exp_q[0];
        want = (beat == 0) ? head[31:0] : head[63:32];
        if (axis.tdata !== want || axis.tlast !== (beat == 1)) begin
          n_err++;
          $display("FAIL beat_data: got tdata=%08h tlast=%0b, want tdata=%08h tlast=%0b",
                   axis.tdata, axis.tlast, want, beat == 1);
        end
        pop = (beat == 1);
        beat = 1 - beat;
      end
    end
    if (sv) begin
      if (exp_q.size() < DEPTH || pop) exp_q.push_back({ch[3], ch[2], ch[1], ch[0]});
      else drop = 1'b1;
    end
    if (clr) begin
      m_drop = drop ? 1 : 0; m_ovf = drop;
    end else if (drop) begin
      if (m_drop < 65535) m_drop++;
      m_ovf = 1'b1;
    end
    if (pop) void'(exp_q.pop_front());
    @(posedge clk); #1;
    if (pv) begin
      n_chk++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tlast !== pl) begin
        n_err++;
        $display("FAIL stall_hold: got v=%0b d=%08h l=%0b, want v=1 d=%08h l=%0b",
                 axis.tvalid, axis.tdata, axis.tlast, pd, pl);
      end
    end
  endtask

  task automatic test_reset();
    axis.tready = 1'b0; axis12.tready = 1'b1;
    for (int k = 0; k < 4; k++) begin ch[k] = '0; ch12[k] = '0; end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) tick();
    n_chk += 6;
    if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %0b want 0", axis.tvalid); end
    if (axis.tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %0b want 0", axis.tlast); end
    if (axis.tdata !== 32'h0) begin n_err++; $display("FAIL rst_tdata: got %08h want 0", axis.tdata); end
    if (lvl !== 4'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", lvl); end
    if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %0b want 0", ovf); end
    if (dcnt !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", dcnt); end
  endtask

  task automatic test_single();
    axis.tready = 1'b1;
    ch[0] = 16'h0001; ch[1] = 16'h0002; ch[2] = 16'h8003; ch[3] = 16'h7FFF;
    sv = 1'b1; tick(); sv = 1'b0;
    n_chk += 2;
    if (lvl !== 4'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", lvl); end
    if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL single_early: got tvalid %0b want 0", axis.tvalid); end
    tick();
    n_chk += 2;
    if (axis.tvalid !== 1'b1 || axis.tlast !== 1'b0) begin n_err++; $display("FAIL single_b1_ctl: got v=%0b l=%0b want v=1 l=0", axis.tvalid, axis.tlast); end
    if (axis.tdata !== 32'h00020001) begin n_err++; $display("FAIL single_b1: got %08h want 00020001", axis.tdata); end
    tick();
    n_chk++;
    if (axis.tdata !== 32'h7FFF8003 || axis.tlast !== 1'b1) begin n_err++; $display("FAIL single_b2: got %08h l=%0b want 7fff8003 l=1", axis.tdata, axis.tlast); end
    tick();
    n_chk += 2;
    if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL single_idle: got tvalid %0b want 0", axis.tvalid); end
    if (lvl !== 4'd0) begin n_err++; $display("FAIL single_level_end: got %0d want 0", lvl); end
  endtask

  task automatic test_sext();
    logic [15:0] e [4];
    int v, lim;
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 4; k++) ch12[k] = 12'($urandom);
      if (n == 0) begin ch12[0] = 12'h800; ch12[1] = 12'h7FF; ch12[2] = 12'h123; ch12[3] = 12'hFFF; end
      for (int k = 0; k < 4; k++) begin
        v = int'(ch12[k]);
        if (v >= 2048) v -= 4096;
        e[k] = 16'(v);
      end
      sv12 = 1'b1; @(posedge clk); #1; sv12 = 1'b0;
      lim = 0;
      while (axis12.tvalid !== 1'b1 && lim < 4) begin @(posedge clk); #1; lim++; end
      n_chk += 2;
      if (axis12.tvalid !== 1'b1) begin n_err++; $display("FAIL sext_timeout: got no tvalid, want beat"); end
      if (axis12.tdata !== {e[1], e[0]}) begin n_err++; $display("FAIL sext_b1: got %08h want %04h%04h", axis12.tdata, e[1], e[0]); end
      @(posedge clk); #1;
      n_chk++;
      if (axis12.tdata !== {e[3], e[2]} || axis12.tlast !== 1'b1) begin n_err++; $display("FAIL sext_b2: got %08h want %04h%04h", axis12.tdata, e[3], e[2]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [63:0] head;
    axis.tready = 1'b1;
    rand_set(); sv = 1'b1; tick(); sv = 1'b0;
    tick(); tick();
    axis.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      head = exp_q[0];
      n_chk++;
      if (axis.tvalid !== 1'b1 || axis.tlast !== 1'b1 || axis.tdata !== head[63:32]) begin
        n_err++; $display("FAIL stall_b2: got v=%0b l=%0b d=%08h want v=1 l=1 d=%08h", axis.tvalid, axis.tlast, axis.tdata, head[63:32]);
      end
    end
    axis.tready = 1'b1; tick();
    n_chk++;
    if (axis.tvalid !== 1'b0 || lvl !== 4'd0) begin n_err++; $display("FAIL stall_done: got v=%0b lvl=%0d want 0 0", axis.tvalid, lvl); end
  endtask

  task automatic test_overflow();
    int lim;
    axis.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_set(); sv = 1'b1; tick(); end
    sv = 1'b0;
    n_chk += 3;
    if (lvl !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", lvl); end
    if (dcnt !== 16'd2 || dcnt !== 16'(m_drop)) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", dcnt); end
    if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
    rand_set(); sv = 1'b1; clr = 1'b1; tick(); sv = 1'b0; clr = 1'b0;
    n_chk++;
    if (dcnt !== 16'd1 || ovf !== 1'b1) begin n_err++; $display("FAIL ovf_clr_drop: got cnt=%0d ovf=%0b want 1 1", dcnt, ovf); end
    clr = 1'b1; tick(); clr = 1'b0;
    n_chk++;
    if (dcnt !== 16'd0 || ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got cnt=%0d ovf=%0b want 0 0", dcnt, ovf); end
    axis.tready = 1'b1;
    lim = 0;
    while (exp_q.size() > 0 && lim < 40) begin tick(); lim++; end
    n_chk++;
    if (exp_q.size() != 0 || lvl !== 4'd0) begin n_err++; $display("FAIL ovf_drain: got %0d sets left lvl=%0d want 0", exp_q.size(), lvl); end
  endtask

  task automatic test_full_pop();
    int lim, d0;
    axis.tready = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_set(); sv = 1'b1; tick(); end
    sv = 1'b0;
    d0 = m_drop;
    axis.tready = 1'b1;
    tick();
    rand_set(); sv = 1'b1; tick(); sv = 1'b0;
    n_chk += 2;
    if (dcnt !== 16'(d0)) begin n_err++; $display("FAIL fullpop_drop: got %0d want %0d", dcnt, d0); end
    if (lvl !== 4'd8) begin n_err++; $display("FAIL fullpop_level: got %0d want 8", lvl); end
    lim = 0;
    while (exp_q.size() > 0 && lim < 40) begin
      n_chk++;
      if (axis.tvalid !== 1'b1) begin n_err++; $display("FAIL fullpop_gap: got tvalid 0 want 1"); end
      tick(); lim++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL fullpop_drain: got %0d sets left want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int lim;
    logic started;
    axis.tready = 1'b1; started = 1'b0;
    rand_set(); sv = 1'b1; tick(); sv = 1'b0;
    tick(); tick();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0 && i < 14) begin rand_set(); sv = 1'b1; end
      tick(); sv = 1'b0;
      if (axis.tvalid === 1'b1) started = 1'b1;
      if (started && exp_q.size() > 0) begin
        n_chk++;
        if (axis.tvalid !== 1'b1) begin n_err++; $display("FAIL b2b_gap: got tvalid 0 at step %0d want 1", i); end
      end
    end
    lim = 0;
    while (exp_q.size() > 0 && lim < 20) begin tick(); lim++; end
    n_chk++;
    if (exp_q.size() != 0 || dcnt !== 16'd0) begin n_err++; $display("FAIL b2b_end: got %0d left drop=%0d want 0 0", exp_q.size(), dcnt); end
  endtask

  task automatic test_random();
    int lim;
    for (int i = 0; i < 300; i++) begin
      rand_set();
      sv = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 39) == 0);
      axis.tready = ($urandom_range(0, 3) != 0);
      tick();
      n_chk += 3;
      if (lvl !== 4'(exp_q.size())) begin n_err++; $display("FAIL rand_level: got %0d want %0d", lvl, exp_q.size()); end
      if (dcnt !== 16'(m_drop)) begin n_err++; $display("FAIL rand_drop: got %0d want %0d", dcnt, m_drop); end
      if (ovf !== m_ovf) begin n_err++; $display("FAIL rand_ovf: got %0b want %0b", ovf, m_ovf); end
    end
    sv = 1'b0; clr = 1'b0; axis.tready = 1'b1;
    lim = 0;
    while (exp_q.size() > 0 && lim < 40) begin tick(); lim++; end
    n_chk++;
    if (exp_q.size() != 0 || lvl !== 4'd0) begin n_err++; $display("FAIL rand_drain: got %0d left lvl=%0d want 0", exp_q.size(), lvl); end
  endtask

  task automatic test_reset_mid();
    int lim;
    logic [15:0] c0, c1;
    axis.tready = 1'b1;
    rand_set(); sv = 1'b1; tick();
    rand_set(); tick(); sv = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got v=%0b l=%0b want 0 0", axis.tvalid, axis.tlast); end
    if (lvl !== 4'd0) begin n_err++; $display("FAIL rstmid_level: got %0d want 0", lvl); end
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) tick();
    n_chk++;
    if (axis.tvalid !== 1'b0 || lvl !== 4'd0) begin n_err++; $display("FAIL rstmid_empty: got v=%0b lvl=%0d want 0 0", axis.tvalid, lvl); end
    rand_set(); c0 = ch[0]; c1 = ch[1];
    sv = 1'b1; tick(); sv = 1'b0;
    tick();
    n_chk++;
    if (axis.tvalid !== 1'b1 || axis.tlast !== 1'b0 || axis.tdata !== {c1, c0}) begin
      n_err++; $display("FAIL rstmid_first: got v=%0b l=%0b d=%08h want v=1 l=0 d=%04h%04h", axis.tvalid, axis.tlast, axis.tdata, c1, c0);
    end
    lim = 0;
    while (exp_q.size() > 0 && lim < 10) begin tick(); lim++; end
    n_chk++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_drain: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_sext();
    test_stall();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
